fetch_queue: RTL and testbench

- Instruction fetch front-end between the instruction memory and the core's decode input.
- Generates sequential fetch addresses and issues one-word reads to instruction memory. The memory has fixed 1-cycle latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready handshake.
- On a core redirect (branch/jump), flushes all buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a credit-limited FIFO and redirect flush
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    inst_valid,
  output logic [XLEN-1:0]         inst,
  output logic [XLEN-1:0]         inst_pc,
  input  logic                    inst_ready,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d, last_inst_q, last_inst_d;
  logic              inflight_q, inflight_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] fifo_q [DEPTH];
  logic [2*XLEN-1:0] head;
  logic              push, pop;
  // Credit-limited issue, FIFO bookkeeping and head output holding; redirect overrides all
  always_comb begin
    head = fifo_q[rptr_q];
    inst_valid = count_q != '0;
    imem_req = reset & ~redirect_valid & ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    imem_addr = fetch_pc_q;
    push = inflight_q & ~redirect_valid;
    pop = inst_valid & inst_ready & ~redirect_valid;
    fetch_pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : imem_req ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    inflight_d = imem_req;
    inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wptr_d = redirect_valid ? '0 : wptr_q + AW'(push);
    rptr_d = redirect_valid ? '0 : rptr_q + AW'(pop);
    last_pc_d = inst_valid ? head[2*XLEN-1:XLEN] : last_pc_q;
    last_inst_d = inst_valid ? head[XLEN-1:0] : last_inst_q;
    inst_pc = inst_valid ? head[2*XLEN-1:XLEN] : last_pc_q;
    inst = inst_valid ? head[XLEN-1:0] : last_inst_q;
    occupancy = count_q;
  end
  // Control and held-output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      last_pc_q <= '0;
      last_inst_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_pc_q <= last_pc_d;
      last_inst_q <= last_inst_d;
    end
  end
  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {inflight_pc_q, imem_rdata};
  end
  // Credit accounting must never let a response land in a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && count_q == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with scoreboard-checked instruction delivery
module tb_fetch_queue;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req, imem_req2, inst_valid, inst_valid2;
  logic [31:0] imem_addr, imem_addr2, inst, inst2, inst_pc, inst_pc2;
  logic [31:0] imem_rdata = '0, imem_rdata2 = '0;
  logic        inst_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  occupancy, occupancy2;
  int          n_checks = 0, n_fail = 0, nreq;
  logic [31:0] exp_q[$], exp2_q[$];
  logic [31:0] e1, e2;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occupancy));

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .occupancy(occupancy2));

  // Instruction memory model: 1-cycle latency, word at address a is ~a
  always @(posedge clk) begin
    imem_rdata <= ~imem_addr;
    imem_rdata2 <= ~imem_addr2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted instruction is compared against the expected queue head
  always @(negedge clk) begin
    if (reset && inst_valid && inst_ready && !redirect_valid && exp_q.size() > 0) begin
      e1 = exp_q.pop_front();
      chk("deliver_pc", inst_pc, e1);
      chk("deliver_inst", inst, ~e1);
    end
    if (reset && inst_valid2 && exp2_q.size() > 0) begin
      e2 = exp2_q.pop_front();
      chk("wrap_pc", inst_pc2, e2);
      chk("wrap_inst", inst2, ~e2);
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || exp2_q.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + exp2_q.size()), 32'd0);
  endtask

  task automatic stream_start(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'(4 * i));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("start_req", 32'(imem_req), 32'd1);
      chk("start_addr", imem_addr, 32'(4 * c));
      chk("start_valid", 32'(inst_valid), 32'(c >= 2));
    end
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    // streaming from reset, plus the wrapping-PC instance
    inst_ready = 1'b1;
    exp2_q.push_back(32'hFFFF_FFF8);
    exp2_q.push_back(32'hFFFF_FFFC);
    exp2_q.push_back(32'h0000_0000);
    exp2_q.push_back(32'h0000_0004);
    stream_start(8);
    // backpressure from reset
    reset = 1'b0;
    inst_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (imem_req) begin
        chk("bp_addr", imem_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    chk("bp_occ", 32'(occupancy), 32'd4);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_head", inst_pc, 32'h0);
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 inst_ready = 1'b0;
    nreq = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (imem_req) begin
        chk("bp_refill_addr", imem_addr, 32'h10);
        nreq++;
      end
    end
    chk("bp_refill_n", 32'(nreq), 32'd1);
    chk("bp_popped", 32'(exp_q.size()), 32'd0);
    chk("bp_occ2", 32'(occupancy), 32'd4);
    chk("bp_head2", inst_pc, 32'h4);
    // redirect with three buffered and one in flight
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    chk("rd_pre_occ", 32'(occupancy), 32'd3);
    chk("rd_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    @(negedge clk);
    chk("rd_occ", 32'(occupancy), 32'd0);
    chk("rd_valid", 32'(inst_valid), 32'd0);
    chk("rd_req1", 32'(imem_req), 32'd1);
    chk("rd_addr", imem_addr, 32'h100);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    drain();
    // redirect colliding with an accepted head
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("rc_valid", 32'(inst_valid), 32'd1);
    chk("rc_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    @(negedge clk);
    chk("rc_occ", 32'(occupancy), 32'd0);
    chk("rc_valid2", 32'(inst_valid), 32'd0);
    chk("rc_addr", imem_addr, 32'h200);
    drain();
    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", 32'(inst_valid), 32'd0);
    chk("ar_inst", inst, 32'h0);
    chk("ar_pc", inst_pc, 32'h0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    stream_start(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
